// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit handshake bundle: run/redirect control, imem req/ack bus, decode-side queue head.
interface fetch_if #(
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32
);

    logic                     trigger;
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     imem_req;
    logic [ADDRESS_WIDTH-1:0] imem_addr;
    logic                     imem_ack;
    logic [DATA_WIDTH-1:0]    imem_rdata;
    logic                     id_valid;
    logic                     id_ready;
    logic [DATA_WIDTH-1:0]    id_instr;
    logic [ADDRESS_WIDTH-1:0] id_pc;

    modport master (
        input  trigger, redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
        output imem_req, imem_addr, id_valid, id_instr, id_pc
    );

    modport slave (
        output trigger, redirect, redirect_pc, imem_ack, imem_rdata, id_ready,
        input  imem_req, imem_addr, id_valid, id_instr, id_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Circular buffer of fetched {pc, instr} words; flush clears pointers and count only.
module fetch_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        do_pop  = pop && (count != '0);
        do_push = push && ((count != CW'(DEPTH)) || do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, imem req/ack sequencing, redirect/drop handling.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 32,
    parameter int unsigned              DATA_WIDTH    = 32,
    parameter int unsigned              QUEUE_DEPTH   = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t                     state;
    fetch_state_t                     state_next;
    fetch_state_t                     resume;
    logic [ADDRESS_WIDTH-1:0]         pc;
    logic [ADDRESS_WIDTH-1:0]         pc_next;
    logic [ADDRESS_WIDTH-1:0]         drop_addr;
    logic [ADDRESS_WIDTH-1:0]         drop_addr_next;
    logic [ADDRESS_WIDTH-1:0]         redirect_target;
    logic [CW-1:0]                    count;
    logic [ADDRESS_WIDTH+DATA_WIDTH-1:0] head;
    logic                             req;
    logic                             ack_hit;
    logic                             push;
    logic                             flush;

    assign req             = ((state == FETCH) && (count < CW'(QUEUE_DEPTH))) || (state == DROP);
    assign ack_hit         = req && bus.imem_ack;
    assign redirect_target = bus.redirect_pc & ~ADDRESS_WIDTH'(3);

    assign bus.imem_req  = req;
    assign bus.imem_addr = (state == DROP) ? drop_addr : pc;
    assign bus.id_valid  = (count != '0);
    assign bus.id_pc     = head[ADDRESS_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign bus.id_instr  = head[DATA_WIDTH-1:0];

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_addr_next = drop_addr;
        push           = 1'b0;
        flush          = 1'b0;
        resume         = bus.trigger ? FETCH : IDLE;

        if (bus.redirect) begin
            flush   = 1'b1;
            pc_next = redirect_target;
            // In DROP the outstanding read is already doomed; only its ack lets us leave.
            if (state == DROP) begin
                if (ack_hit) begin
                    state_next = resume;
                end
            end else if (req && !bus.imem_ack) begin
                drop_addr_next = pc;
                state_next     = DROP;
            end else begin
                state_next = resume;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.trigger) begin
                        state_next = FETCH;
                    end
                end
                FETCH: begin
                    if (ack_hit) begin
                        push    = 1'b1;
                        pc_next = pc + ADDRESS_WIDTH'(PC_STEP);
                    end
                    if (!bus.trigger && (ack_hit || !req)) begin
                        state_next = IDLE;
                    end
                end
                DROP: begin
                    if (ack_hit) begin
                        state_next = resume;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            drop_addr <= '0;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            drop_addr <= drop_addr_next;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ADDRESS_WIDTH + DATA_WIDTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pc, bus.imem_rdata}),
        .pop       (bus.id_ready),
        .flush     (flush),
        .count     (count),
        .head      (head)
    );

endmodule
